// File: rtl/cordic_rot_seq.sv
// rtl/cordic_rot_seq.sv - iterative CORDIC rotation sequencer driving an external shift/add stage
// Optional gain compensation: define CORDIC_GAIN_COMP_EN to add a SCALE state before DONE.
module cordic_rot_seq #(
  parameter int ITER = 14,
  parameter int W    = 16
) (
  input  logic         Clk_i,
  input  logic         Rst_ni,
  input  logic         Start_i,
  output logic         Ready_o,
  input  logic [W-1:0] X_i,
  input  logic [W-1:0] Y_i,
  input  logic [W-1:0] Z_i,
  output logic [W-1:0] RotX_o,
  output logic [W-1:0] RotY_o,
  output logic [3:0]   RotShift_o,
  output logic         RotSign_o,
  input  logic [W-1:0] RotX_i,
  input  logic [W-1:0] RotY_i,
  output logic         Valid_o,
  output logic [W-1:0] X_o,
  output logic [W-1:0] Y_o,
  input  logic         Ack_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [3:0]   LAST_ITER = 4'(ITER - 1);
  localparam logic [W-1:0] HALF_TURN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS   = {1'b0, {(W-1){1'b1}}};

  state_e       state_q, state_d;
  logic [3:0]   iter_q, iter_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] z_q, z_d;
  logic         fold;
  logic         issue;

  // atan(2^-i) in binary-angle units, rounded to nearest
  function automatic logic [W-1:0] atan_lut(input logic [3:0] idx);
    logic [15:0] a;
    case (idx)
      4'd0:    a = 16'h2000;
      4'd1:    a = 16'h12E4;
      4'd2:    a = 16'h09FB;
      4'd3:    a = 16'h0511;
      4'd4:    a = 16'h028B;
      4'd5:    a = 16'h0146;
      4'd6:    a = 16'h00A3;
      4'd7:    a = 16'h0051;
      4'd8:    a = 16'h0029;
      4'd9:    a = 16'h0014;
      4'd10:   a = 16'h000A;
      4'd11:   a = 16'h0005;
      4'd12:   a = 16'h0003;
      4'd13:   a = 16'h0001;
      4'd14:   a = 16'h0001;
      default: a = 16'h0000;
    endcase
    return W'(a);
  endfunction

  // Negation with the most negative code clamped, so a fold never flips its sign back
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
    if (v == HALF_TURN) begin
      return MAX_POS;
    end
    return -v;
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [31:0] INV_GAIN = 32'sh0000_26DD;
  localparam logic signed [31:0] RND_HALF = 32'sh0000_2000;

  function automatic logic [W-1:0] gain_comp(input logic [W-1:0] v);
    logic signed [31:0] p;
    p = 32'(signed'(v)) * INV_GAIN + RND_HALF;
    return W'(p >>> 14);
  endfunction
`endif

  // Angles beyond +/-90 deg lie outside CORDIC convergence: rotate by 180 deg up front
  assign fold  = Z_i[W-1] ^ Z_i[W-2];
  assign issue = (state_q == S_ISSUE);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          iter_d  = '0;
          state_d = S_ISSUE;
          if (fold) begin
            x_d = neg_sat(X_i);
            y_d = neg_sat(Y_i);
            z_d = Z_i + HALF_TURN;
          end else begin
            x_d = X_i;
            y_d = Y_i;
            z_d = Z_i;
          end
        end
      end
      S_ISSUE: begin
        if (z_q[W-1]) begin
          z_d = z_q + atan_lut(iter_q);
        end else begin
          z_d = z_q - atan_lut(iter_q);
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        x_d = RotX_i;
        y_d = RotY_i;
        if (iter_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_SCALE;
`else
          state_d = S_DONE;
`endif
        end else begin
          iter_d  = iter_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
        x_d = gain_comp(x_q);
        y_d = gain_comp(y_q);
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (Ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Stage-side outputs are only meaningful during ISSUE; held at zero otherwise
  assign RotX_o     = issue ? x_q : '0;
  assign RotY_o     = issue ? y_q : '0;
  assign RotShift_o = issue ? iter_q : 4'd0;
  assign RotSign_o  = issue & z_q[W-1];

  assign Ready_o = (state_q == S_IDLE);
  assign Valid_o = (state_q == S_DONE);
  assign X_o     = Valid_o ? x_q : '0;
  assign Y_o     = Valid_o ? y_q : '0;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// tb/tb_cordic_rot_seq.sv - directed bench for cordic_rot_seq with a registered shift/add stage model
// Expectations follow the build: CORDIC_GAIN_COMP_EN selects the scaled input and longer latency.
module tb_cordic_rot_seq;

  localparam int ITER = 14;
  localparam int TOL  = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int          LAT = 2 * ITER + 2;
  localparam logic [15:0] X0  = 16'h4000;
`else
  localparam int          LAT = 2 * ITER + 1;
  localparam logic [15:0] X0  = 16'h26DD;
`endif

  logic        Clk_i = 1'b0;
  logic        Rst_ni = 1'b0;
  logic        Start_i = 1'b0;
  logic        Ready_o;
  logic [15:0] X_i = '0, Y_i = '0, Z_i = '0;
  logic [15:0] RotX_o, RotY_o;
  logic [3:0]  RotShift_o;
  logic        RotSign_o;
  logic [15:0] RotX_i = '0, RotY_i = '0;
  logic        Valid_o;
  logic [15:0] X_o, Y_o;
  logic        Ack_i = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  cordic_rot_seq #(.ITER(ITER), .W(16)) dut (
    .Clk_i(Clk_i), .Rst_ni(Rst_ni), .Start_i(Start_i), .Ready_o(Ready_o),
    .X_i(X_i), .Y_i(Y_i), .Z_i(Z_i),
    .RotX_o(RotX_o), .RotY_o(RotY_o), .RotShift_o(RotShift_o), .RotSign_o(RotSign_o),
    .RotX_i(RotX_i), .RotY_i(RotY_i),
    .Valid_o(Valid_o), .X_o(X_o), .Y_o(Y_o), .Ack_i(Ack_i)
  );

  always #5 Clk_i = ~Clk_i;

  // Registered micro-rotation stage, one cycle of latency
  logic signed [15:0] sx, sy, shx, shy;
  always_comb begin
    sx  = RotX_o;
    sy  = RotY_o;
    shx = sx >>> RotShift_o;
    shy = sy >>> RotShift_o;
  end
  always @(posedge Clk_i) begin
    RotX_i <= RotSign_o ? sx + shy : sx - shy;
    RotY_i <= RotSign_o ? sy - shx : sy + shx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    int d;
    d = int'($signed(obs)) - int'($signed(exp));
    if (d < 0) d = -d;
    n_cmp++;
    assert (d <= TOL) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h +/-%0d", tag, obs, exp, TOL);
    end
  endtask

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic release_result();
    Ack_i = 1'b1;
    tick();
    Ack_i = 1'b0;
  endtask

  // Accepts a job, records the shift/sign sequence seen by the stage, then waits (bounded) for Valid_o
  task automatic run_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         output logic shifts_ok, output logic early, output logic [15:0] signs,
                         output int lat);
    X_i = x; Y_i = y; Z_i = z; Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
    lat = 1; signs = '0; shifts_ok = 1'b1; early = 1'b0;
    for (int k = 0; k < ITER; k++) begin
      if (RotShift_o !== 4'(k)) shifts_ok = 1'b0;
      signs[k] = RotSign_o;
      if (Valid_o) early = 1'b1;
      tick();
      if (Valid_o) early = 1'b1;
      tick();
      lat += 2;
    end
    while (!Valid_o && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  logic        sh_ok, early, stable, ready_seen;
  logic [15:0] signs, hx, hy;
  int          lat;

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_ready", Ready_o, 1'b1);
    check("rst_valid", Valid_o, 1'b0);
    check("rst_xo", X_o, 16'h0000);
    check("rst_rotx", RotX_o, 16'h0000);
    check("rst_rotshift", RotShift_o, 4'd0);
    Rst_ni = 1'b1;
    tick();

    // 1: +45 deg
    check("t1_ready_before", Ready_o, 1'b1);
    run_job(X0, 16'h0000, 16'h2000, sh_ok, early, signs, lat);
    check("t1_shift_seq", sh_ok, 1'b1);
    check("t1_no_early_valid", early, 1'b0);
    check("t1_latency", lat, LAT);
    check("t1_sign_seq", signs, 16'h107C);
    check_near("t1_x", X_o, 16'h2D41);
    check_near("t1_y", Y_o, 16'h2D41);

    // 4: hold in DONE with Ack low, Start pulses must be ignored
    hx = X_o; hy = Y_o; stable = 1'b1; ready_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Start_i = (k == 1 || k == 2);
      tick();
      if (!Valid_o || X_o !== hx || Y_o !== hy) stable = 1'b0;
      if (Ready_o) ready_seen = 1'b1;
    end
    check("t4_result_stable", stable, 1'b1);
    check("t4_ready_low", ready_seen, 1'b0);
    Ack_i = 1'b1; Start_i = 1'b1;
    tick();
    Ack_i = 1'b0; Start_i = 1'b0;
    check("t4_valid_drop", Valid_o, 1'b0);
    check("t4_idle_after_ack", Ready_o, 1'b1);
    tick();
    check("t4_no_accept_with_ack", Ready_o, 1'b1);

    // 2: -90 deg, boundary without fold
    run_job(X0, 16'h0000, 16'hC000, sh_ok, early, signs, lat);
    check("t2_latency", lat, LAT);
    check("t2_sign_seq", signs, 16'h0F2F);
    check_near("t2_x", X_o, 16'h0000);
    check_near("t2_y", Y_o, 16'hC000);
    release_result();

    // 3: 180 deg, quadrant fold
    run_job(X0, 16'h0000, 16'h8000, sh_ok, early, signs, lat);
    check("t3_latency", lat, LAT);
    check("t3_sign_seq", signs, 16'h0F2E);
    check_near("t3_x", X_o, 16'hC000);
    check_near("t3_y", Y_o, 16'h0000);
    release_result();

    // 5: reset during iteration 6 aborts the job
    X_i = X0; Y_i = 16'h0000; Z_i = 16'h2000; Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
    repeat (12) tick();
    check("t5_at_iter6", RotShift_o, 4'd6);
    Rst_ni = 1'b0;
    tick();
    Rst_ni = 1'b1;
    check("t5_ready", Ready_o, 1'b1);
    check("t5_valid", Valid_o, 1'b0);
    check("t5_xo", X_o, 16'h0000);
    check("t5_rotx", RotX_o, 16'h0000);
    early = 1'b0;
    repeat (3) begin
      tick();
      if (Valid_o || !Ready_o) early = 1'b1;
    end
    check("t5_stays_idle", early, 1'b0);
    run_job(X0, 16'h0000, 16'h2000, sh_ok, early, signs, lat);
    check("t5_shift_seq", sh_ok, 1'b1);
    check("t5_latency", lat, LAT);
    check("t5_sign_seq", signs, 16'h107C);
    check_near("t5_x", X_o, 16'h2D41);
    check_near("t5_y", Y_o, 16'h2D41);
    release_result();
    check("t5_final_idle", Ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
